// File: rtl/pixel_scanout.sv
// Raster timing generator plus small pixel FIFO that scans a 32-bit RGBA stream out as 8-bit RGB,
// with underflow/misalignment detection and re-sync on the next start-of-frame word.
module pixel_scanout #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int FIFO_DEPTH      = 4,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_start,
  output logic        underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {S_RESYNC, S_WAIT, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [HW-1:0]   r_h;
  logic [VW-1:0]   r_v;
  logic [24:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;

  logic            r_hsync, r_vsync, r_de, r_fs, r_uf;
  logic [23:0]     r_rgb;

  logic [HW:0]     w_hx;
  logic [VW:0]     w_vx;
  logic            w_active, w_origin, w_hs_raw, w_vs_raw;
  logic            w_full, w_empty, w_push_ok;
  logic            w_run, w_err, w_pop, w_push, w_flush;
  logic [24:0]     w_head;
  logic            w_unused_alpha;

  // Alpha is never displayed, so it is not stored.
  assign w_unused_alpha = ^in_data[7:0];

  assign w_hx     = {1'b0, r_h};
  assign w_vx     = {1'b0, r_v};
  assign w_active = (w_hx < (HW+1)'(H_ACTIVE)) && (w_vx < (VW+1)'(V_ACTIVE));
  assign w_origin = (r_h == '0) && (r_v == '0);
  assign w_hs_raw = (w_hx >= (HW+1)'(H_ACTIVE + H_FP)) &&
                    (w_hx <  (HW+1)'(H_ACTIVE + H_FP + H_SYNC));
  assign w_vs_raw = (w_vx >= (VW+1)'(V_ACTIVE + V_FP)) &&
                    (w_vx <  (VW+1)'(V_ACTIVE + V_FP + V_SYNC));

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign w_push_ok = in_valid && in_ready;
  assign w_head    = r_mem[r_rptr];

  // WAIT_FRAME already behaves as RUN on the origin cycle so pixel (0,0) is popped there.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_err       = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_RESYNC: if (w_push_ok && in_sof) begin
        w_push      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_push = w_push_ok;
        if (w_origin) begin
          w_run       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_push = w_push_ok;
        w_run  = 1'b1;
      end
      default: w_state_nxt = S_RESYNC;
    endcase
    if (w_run && w_active) begin
      if (w_empty || (w_head[24] != w_origin)) begin
        w_err       = 1'b1;
        w_push      = 1'b0;
        w_flush     = 1'b1;
        w_state_nxt = S_RESYNC;
      end else begin
        w_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESYNC;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_h == HW'(H_TOTAL - 1)) begin
        r_h <= '0;
        r_v <= (r_v == VW'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (w_push) r_mem[r_wptr] <= {in_sof, in_data[31:8]};
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_hsync <= SYNC_IDLE;
      r_vsync <= SYNC_IDLE;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
      r_uf    <= 1'b0;
    end else begin
      r_hsync <= w_hs_raw ^ SYNC_IDLE;
      r_vsync <= w_vs_raw ^ SYNC_IDLE;
      r_de    <= w_active;
      r_rgb   <= w_pop ? w_head[23:0] : 24'h0;
      r_fs    <= w_pop && w_origin;
      r_uf    <= r_uf | w_err;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign red         = r_rgb[23:16];
  assign green       = r_rgb[15:8];
  assign blue        = r_rgb[7:0];
  assign frame_start = r_fs;
  assign underflow   = r_uf;

endmodule

// File: tb/tb_pixel_scanout.sv
// Bench for pixel_scanout on a 7x5 raster: timing table, directed stream/underflow/misalign/reset
// sequences, and randomized streams compared against a queue-based reference model.
module tb_pixel_scanout;
  localparam int HA = 4, HF = 1, HS = 1, HB = 1, VA = 2, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT, DEP = 4;

  logic        pixel_clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, hsync, vsync, de, frame_start, underflow;
  logic [7:0]  red, green, blue;

  pixel_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                  .FIFO_DEPTH(DEP), .SYNC_ACTIVE_LOW(1)) dut (
    .pixel_clk(pixel_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .hsync(hsync), .vsync(vsync), .de(de),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start), .underflow(underflow));

  always #5 pixel_clk = ~pixel_clk;

  typedef struct { int cyc; logic de; logic hs; logic vs; } tvec_t;
  tvec_t tbl[12];

  int ntests = 0, nfail = 0, kc = 0, nready0 = 0, nfs = 0;
  logic [7:0] obs_red [0:127];
  bit         obs_fs  [0:127];

  // reference model: frame position from elapsed cycles, FIFO as a queue
  logic [32:0] mq[$];
  logic [32:0] src[$];
  int  mt, mode;
  bit  muf, gate = 1, auto_fill = 0, rnd_frames = 0;
  int  vprob = 100;
  bit  e_de, e_hs, e_vs, e_fs;
  logic [23:0] e_rgb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, kc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete(); mt = 0; mode = 0; muf = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit s, output bit acc);
    int h, vv;
    bit act, org, run, bad;
    h = mt % HT; vv = (mt / HT) % VT;
    act = (h < HA) && (vv < VA);
    org = (mt % FT) == 0;
    bad = 0;
    acc = v && (mq.size() < DEP);
    e_de = act;
    e_hs = !(h >= HA + HF && h < HA + HF + HS);
    e_vs = !(vv >= VA + VF && vv < VA + VF + VS);
    e_rgb = '0; e_fs = 0;
    if (mode == 0) begin
      if (acc && s) begin mq.push_back({s, d}); mode = 1; end
    end else begin
      run = (mode == 2) || org;
      if (run && act) begin
        if (mq.size() == 0 || mq[0][32] != org) bad = 1;
        else begin e_rgb = mq[0][31:8]; e_fs = org; void'(mq.pop_front()); end
      end
      if (bad) begin mq.delete(); mode = 0; muf = 1; end
      else begin
        if (run) mode = 2;
        if (acc) mq.push_back({s, d});
      end
    end
    mt++;
  endtask

  task automatic add_frame(input int base);
    for (int i = 0; i < HA * VA; i++) src.push_back({i == 0, 8'(base + i), 24'h0});
  endtask

  task automatic add_rframe();
    int bad_i;
    bad_i = ($urandom_range(19) == 0) ? $urandom_range(HA * VA - 1) : -1;
    for (int i = 0; i < HA * VA; i++)
      src.push_back({(i == 0) ^ (i == bad_i), 32'($urandom)});
  endtask

  task automatic cycle();
    bit v, acc;
    logic [32:0] w;
    if (auto_fill && src.size() < 16) begin
      if (rnd_frames) add_rframe(); else add_frame(1);
    end
    w = (src.size() > 0) ? src[0] : {1'b0, 32'($urandom)};
    v = gate && (src.size() > 0) && ($urandom_range(99) < vprob);
    in_valid = v; in_data = w[31:0]; in_sof = w[32];
    chk("in_ready", in_ready, mq.size() < DEP);
    if (!in_ready) nready0++;
    model_step(v, w[31:0], w[32], acc);
    if (acc) void'(src.pop_front());
    @(posedge pixel_clk); #1;
    kc++;
    chk("de", de, e_de);
    chk("hsync", hsync, e_hs);
    chk("vsync", vsync, e_vs);
    chk("rgb", {red, green, blue}, e_rgb);
    chk("frame_start", frame_start, e_fs);
    chk("underflow", underflow, muf);
    if (frame_start) nfs++;
    if (kc < 128) begin obs_red[kc] = red; obs_fs[kc] = frame_start; end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_rgb"}, {red, green, blue}, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_uf"}, underflow, 0);
    chk({tag, "_ready"}, in_ready, 1);
  endtask

  task automatic release_reset();
    rst = 1'b0; in_valid = 1'b0;
    model_reset(); kc = 0; nfs = 0; nready0 = 0;
    src.delete();
    for (int i = 0; i < 128; i++) begin obs_red[i] = '0; obs_fs[i] = 0; end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge pixel_clk);
    #1;
    chk_rst(tag);
    release_reset();
  endtask

  initial begin
    int nz, j, nfs_inj;
    // sample index k describes counter position k-1
    tbl[0]  = '{1,  1, 1, 1};  tbl[1]  = '{4,  1, 1, 1};
    tbl[2]  = '{5,  0, 1, 1};  tbl[3]  = '{6,  0, 0, 1};
    tbl[4]  = '{7,  0, 1, 1};  tbl[5]  = '{8,  1, 1, 1};
    tbl[6]  = '{15, 0, 1, 1};  tbl[7]  = '{20, 0, 0, 1};
    tbl[8]  = '{22, 0, 1, 0};  tbl[9]  = '{27, 0, 0, 0};
    tbl[10] = '{29, 0, 1, 1};  tbl[11] = '{36, 1, 1, 1};

    // reset timing with no input
    do_reset("rst1");
    auto_fill = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      for (int t = 0; t < 12; t++) if (tbl[t].cyc == kc) begin
        chk("tbl_de", de, tbl[t].de);
        chk("tbl_hsync", hsync, tbl[t].hs);
        chk("tbl_vsync", vsync, tbl[t].vs);
      end
    end

    // normal stream under constant backpressure
    do_reset("rst2");
    auto_fill = 1; rnd_frames = 0; gate = 1; vprob = 100;
    repeat (80) cycle();
    nz = 0;
    for (int k = 1; k <= 35; k++) if (obs_red[k] != 0 || obs_fs[k]) nz++;
    chk("first_frame_black", nz, 0);
    chk("fs_at_36", obs_fs[36], 1);
    for (int i = 0; i < 4; i++) begin
      chk("line0_red", obs_red[36 + i], i + 1);
      chk("line1_red", obs_red[43 + i], i + 5);
      chk("frame3_red", obs_red[71 + i], i + 1);
    end
    chk("backpressure_seen", nready0 > 0, 1);
    chk("no_underflow", underflow, 0);

    // underflow: 6-cycle gap starting at h=1 of line 0
    for (int i = 0; i < 2 * FT && (mt % FT) != 1; i++) cycle();
    gate = 0;
    repeat (6) cycle();
    gate = 1;
    cycle();
    chk("uf_rise", underflow, 1);
    chk("uf_black", {red, green, blue}, 0);
    nfs_inj = nfs;
    repeat (150) cycle();
    chk("uf_resync", nfs > nfs_inj, 1);
    chk("uf_sticky", underflow, 1);

    // misalignment: sof on the 3rd pixel of an upcoming frame
    do_reset("rst5");
    auto_fill = 1;
    repeat (80) cycle();
    while (src.size() < 24) add_frame(1);
    j = 0;
    for (int i = 0; i < src.size(); i++) if (src[i][32]) begin j = i; break; end
    src[j + 2][32] = 1'b1;
    chk("pre_misalign_uf", underflow, 0);
    nfs_inj = nfs;
    repeat (175) cycle();
    chk("misalign_uf", underflow, 1);
    chk("misalign_realign", nfs >= nfs_inj + 2, 1);

    // asynchronous reset while at counter (2,1) in RUN
    for (int i = 0; i < 3 * FT && !(mode == 2 && (mt % FT) == HT + 2); i++) cycle();
    chk("mid_reset_reached", (mode == 2) && ((mt % FT) == HT + 2), 1);
    #2 rst = 1'b1;
    #1 chk_rst("async");
    @(posedge pixel_clk); @(posedge pixel_clk); #1;
    release_reset();
    auto_fill = 1;
    repeat (40) cycle();
    nz = 0;
    for (int k = 1; k <= 35; k++) if (obs_red[k] != 0 || obs_fs[k]) nz++;
    chk("post_reset_black", nz, 0);
    chk("post_reset_fs", obs_fs[36], 1);

    // randomized streams with stalls and occasional sof corruption
    for (int r = 0; r < 6; r++) begin
      do_reset("rstr");
      auto_fill = 1; rnd_frames = 1; gate = 1;
      vprob = 80 + $urandom_range(20);
      repeat (300) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
